// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the decode-side branch resolver: opcodes, condition
// codes, flag layout and the IF/ID slot record.
package branch_pkg;

    localparam logic [3:0]  OP_B     = 4'hC;
    localparam logic [3:0]  OP_BR    = 4'hD;
    localparam logic [15:0] NOP_INST = 16'h0000;

    typedef enum logic [2:0] {
        NE     = 3'd0,
        EQ     = 3'd1,
        GT     = 3'd2,
        LT     = 3'd3,
        GTE    = 3'd4,
        LTE    = 3'd5,
        OV     = 3'd6,
        UNCOND = 3'd7
    } cond_t;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] pc_curr;
        logic [15:0] pc_next;
        logic [15:0] inst;
        logic [1:0]  prediction;
        logic [15:0] predicted_target;
    } if_id_t;

    // B displacement: 9-bit signed halfword offset scaled to a byte offset.
    function automatic logic [15:0] b_offset(input logic [8:0] imm);
        return {{6{imm[8]}}, imm, 1'b0};
    endfunction

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational branch condition evaluator; also intended for reuse by the
// EX-stage branch checker.
module branch_cond_eval
    import branch_pkg::*;
(
    input  cond_t  cond_i,
    input  flags_t flags_i,
    output logic   taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            NE:      taken_o = ~flags_i.z;
            EQ:      taken_o = flags_i.z;
            GT:      taken_o = ~flags_i.z & ~flags_i.n;
            LT:      taken_o = flags_i.n;
            GTE:     taken_o = flags_i.z | (~flags_i.z & ~flags_i.n);
            LTE:     taken_o = flags_i.n | flags_i.z;
            OV:      taken_o = flags_i.v;
            UNCOND:  taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolver: IF/ID register, condition/target resolution,
// predictor update enables, Fetch redirect and saturating statistics.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flags_busy,
    input  logic [15:0]      PC_curr,
    input  logic [15:0]      PC_next,
    input  logic [15:0]      PC_inst,
    input  logic [1:0]       prediction,
    input  logic [15:0]      predicted_target,
    input  logic [2:0]       flags,
    input  logic [15:0]      rs_data,
    input  logic             stats_clr,
    output logic [15:0]      IF_ID_PC_curr,
    output logic [1:0]       IF_ID_prediction,
    output logic [15:0]      IF_ID_inst,
    output logic             actual_taken,
    output logic [15:0]      actual_target,
    output logic             wen_BTB,
    output logic             wen_BHT,
    output logic             update_PC,
    output logic             branch_stall,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    if_id_t           ifid_q, ifid_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

    logic [3:0]  opcode;
    cond_t       cond;
    flags_t      flags_s;
    logic        cond_true;
    logic        is_branch;
    logic        blocked;
    logic        resolved;
    logic        taken;
    logic        mispredicted;
    logic        miscomputed;
    logic [15:0] target;

    assign opcode    = ifid_q.inst[15:12];
    assign cond      = cond_t'(ifid_q.inst[11:9]);
    assign flags_s   = flags_t'(flags);
    assign is_branch = ifid_q.valid & ((opcode == OP_B) | (opcode == OP_BR));

    branch_cond_eval u_cond_eval (
        .cond_i  (cond),
        .flags_i (flags_s),
        .taken_o (cond_true)
    );

    assign target       = (opcode == OP_BR) ? rs_data
                                            : ifid_q.pc_next + b_offset(ifid_q.inst[8:0]);
    assign taken        = is_branch & cond_true;
    assign mispredicted = ifid_q.prediction[1] != taken;
    assign miscomputed  = ifid_q.predicted_target != target;

    // A conditional branch cannot resolve while EX is still producing flags.
    assign branch_stall = is_branch & flags_busy & (cond != UNCOND);
    assign blocked      = stall | branch_stall;
    assign resolved     = is_branch & ~blocked;

    assign actual_taken  = taken;
    assign actual_target = !ifid_q.valid ? '0 : (taken ? target : ifid_q.pc_next);
    assign wen_BHT       = resolved & mispredicted;
    assign wen_BTB       = resolved & (taken | miscomputed);
    assign update_PC     = resolved & (mispredicted | (taken & miscomputed));

    assign IF_ID_PC_curr    = ifid_q.pc_curr;
    assign IF_ID_prediction = ifid_q.prediction;
    assign IF_ID_inst       = ifid_q.inst;
    assign branch_cnt       = branch_cnt_q;
    assign redirect_cnt     = redirect_cnt_q;

    always_comb begin
        ifid_d = ifid_q;
        if (update_PC) begin
            // Wrong-path instruction becomes a bubble, whatever Fetch delivered.
            ifid_d      = '0;
            ifid_d.inst = NOP_INST;
        end else if (!blocked) begin
            ifid_d = '{valid:            1'b1,
                       pc_curr:          PC_curr,
                       pc_next:          PC_next,
                       inst:             PC_inst,
                       prediction:       prediction,
                       predicted_target: predicted_target};
        end
    end

    always_comb begin
        branch_cnt_d   = branch_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        if (stats_clr) begin
            branch_cnt_d   = '0;
            redirect_cnt_d = '0;
        end else begin
            if (resolved && (branch_cnt_q != '1))
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            if (update_PC && (redirect_cnt_q != '1))
                redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q         <= '0;
            branch_cnt_q   <= '0;
            redirect_cnt_q <= '0;
        end else begin
            ifid_q         <= ifid_d;
            branch_cnt_q   <= branch_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus a
// randomized run against a behavioural model of the decode-stage slot.
module tb_branch_resolve_unit;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int OUT_W = 16 + 2 + 16 + 1 + 16 + 4 + 2 * CNT_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             stall = 1'b0;
    logic             flags_busy = 1'b0;
    logic             stats_clr = 1'b0;
    logic [15:0]      PC_curr = '0;
    logic [15:0]      PC_next = '0;
    logic [15:0]      PC_inst = '0;
    logic [1:0]       prediction = '0;
    logic [15:0]      predicted_target = '0;
    logic [2:0]       flags = '0;
    logic [15:0]      rs_data = '0;
    logic [15:0]      IF_ID_PC_curr;
    logic [1:0]       IF_ID_prediction;
    logic [15:0]      IF_ID_inst;
    logic             actual_taken;
    logic [15:0]      actual_target;
    logic             wen_BTB;
    logic             wen_BHT;
    logic             update_PC;
    logic             branch_stall;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] redirect_cnt;
    logic [OUT_W-1:0] all_out;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .flags_busy       (flags_busy),
        .PC_curr          (PC_curr),
        .PC_next          (PC_next),
        .PC_inst          (PC_inst),
        .prediction       (prediction),
        .predicted_target (predicted_target),
        .flags            (flags),
        .rs_data          (rs_data),
        .stats_clr        (stats_clr),
        .IF_ID_PC_curr    (IF_ID_PC_curr),
        .IF_ID_prediction (IF_ID_prediction),
        .IF_ID_inst       (IF_ID_inst),
        .actual_taken     (actual_taken),
        .actual_target    (actual_target),
        .wen_BTB          (wen_BTB),
        .wen_BHT          (wen_BHT),
        .update_PC        (update_PC),
        .branch_stall     (branch_stall),
        .branch_cnt       (branch_cnt),
        .redirect_cnt     (redirect_cnt)
    );

    assign all_out = {IF_ID_PC_curr, IF_ID_prediction, IF_ID_inst, actual_taken, actual_target,
                      wen_BTB, wen_BHT, update_PC, branch_stall, branch_cnt, redirect_cnt};

    always #5 clk = ~clk;

    // Reference model: the decode slot as plain variables, outputs from the rules.
    bit       m_valid;
    int       m_pc, m_pcn, m_inst, m_ptgt;
    bit [1:0] m_pred;
    int       m_bcnt, m_rcnt;

    typedef struct {
        bit taken;
        int target;
        bit wbtb, wbht, upd, bstall, resolved;
    } exp_t;

    function automatic int b_target(input int pcn, input int inst);
        int off;
        off = inst & 511;
        if (off >= 256) off -= 512;
        return (pcn + off * 2) & 32'hFFFF;
    endfunction

    function automatic exp_t model_eval();
        exp_t e;
        int   op, c, tgt;
        bit   z, v, n, ct, isb;
        op  = (m_inst >> 12) & 15;
        c   = (m_inst >> 9) & 7;
        z   = flags[2];
        v   = flags[1];
        n   = flags[0];
        isb = m_valid && (op == 12 || op == 13);
        case (c)
            0: ct = !z;
            1: ct = z;
            2: ct = !z && !n;
            3: ct = n;
            4: ct = z || (!z && !n);
            5: ct = n || z;
            6: ct = v;
            default: ct = 1'b1;
        endcase
        tgt        = (op == 13) ? int'(rs_data) : b_target(m_pcn, m_inst);
        e.taken    = isb && ct;
        e.target   = !m_valid ? 0 : (e.taken ? tgt : m_pcn);
        e.bstall   = isb && flags_busy && (c != 7);
        e.resolved = isb && !e.bstall && !stall;
        e.wbht     = e.resolved && (m_pred[1] != e.taken);
        e.wbtb     = e.resolved && (e.taken || (m_ptgt != tgt));
        e.upd      = e.resolved && ((m_pred[1] != e.taken) || (e.taken && (m_ptgt != tgt)));
        return e;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_pc = 0; m_pcn = 0; m_inst = 0; m_ptgt = 0; m_pred = 0;
        m_bcnt = 0; m_rcnt = 0;
    endtask

    task automatic model_advance(input exp_t e);
        if (stats_clr) begin
            m_bcnt = 0;
            m_rcnt = 0;
        end else begin
            if (e.resolved && m_bcnt < CMAX) m_bcnt++;
            if (e.upd && m_rcnt < CMAX) m_rcnt++;
        end
        if (e.upd) begin
            m_valid = 0; m_pc = 0; m_pcn = 0; m_inst = 0; m_ptgt = 0; m_pred = 0;
        end else if (!(stall || e.bstall)) begin
            m_valid = 1;
            m_pc    = PC_curr;
            m_pcn   = PC_next;
            m_inst  = PC_inst;
            m_pred  = prediction;
            m_ptgt  = predicted_target;
        end
    endtask

    task automatic step();
        exp_t e;
        e = model_eval();
        model_advance(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] pc, input logic [15:0] inst,
                         input logic [1:0] pred, input logic [15:0] ptgt);
        PC_curr          = pc;
        PC_next          = pc + 16'd2;
        PC_inst          = inst;
        prediction       = pred;
        predicted_target = ptgt;
    endtask

    task automatic do_reset();
        rst_n = 0; stall = 0; flags_busy = 0; stats_clr = 0; flags = 0; rs_data = 0;
        fetch(16'h0000, 16'h0000, 2'b00, 16'h0000);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        fetch(16'h1230, 16'hC203, 2'b11, 16'hBEEF);
        flags = 3'b111;
        #2;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        do_reset();
    endtask

    task automatic test_taken_redirect();
        do_reset();
        flags = 3'b100;
        fetch(16'h0010, 16'hC203, 2'b00, 16'h0000);
        step();
        fetch(16'h0012, 16'h1234, 2'b00, 16'h0000);
        #1;
        checks++;
        if ({actual_taken, wen_BTB, wen_BHT, update_PC} !== 4'b1111) begin
            errors++;
            $display("FAIL beq_flags: got %b expected 1111",
                     {actual_taken, wen_BTB, wen_BHT, update_PC});
        end
        checks++;
        if (actual_target !== 16'h0018) begin
            errors++;
            $display("FAIL beq_target: got %h expected 0018", actual_target);
        end
        step();
        checks++;
        if ({IF_ID_inst, redirect_cnt, branch_cnt} !== {16'h0000, 4'd1, 4'd1}) begin
            errors++;
            $display("FAIL beq_flush: got inst=%h rcnt=%0d bcnt=%0d expected 0000/1/1",
                     IF_ID_inst, redirect_cnt, branch_cnt);
        end
    endtask

    task automatic test_not_taken_mispredict();
        do_reset();
        flags = 3'b100;
        fetch(16'h0020, 16'hC004, 2'b11, 16'h0030);
        step();
        fetch(16'h0022, 16'h5555, 2'b00, 16'h0000);
        #1;
        checks++;
        if ({actual_taken, wen_BTB, wen_BHT, update_PC} !== 4'b0111) begin
            errors++;
            $display("FAIL bne_flags: got %b expected 0111",
                     {actual_taken, wen_BTB, wen_BHT, update_PC});
        end
        checks++;
        if (actual_target !== 16'h0022) begin
            errors++;
            $display("FAIL bne_target: got %h expected 0022", actual_target);
        end
    endtask

    task automatic test_br_uncond();
        do_reset();
        rs_data = 16'h0040;
        fetch(16'h0050, 16'hDE10, 2'b10, 16'h0040);
        step();
        fetch(16'h0052, 16'h1111, 2'b00, 16'h0000);
        #1;
        checks++;
        if ({actual_taken, wen_BTB, wen_BHT, update_PC, actual_target} !== {4'b1100, 16'h0040}) begin
            errors++;
            $display("FAIL br_uncond: got %b/%h expected 1100/0040",
                     {actual_taken, wen_BTB, wen_BHT, update_PC}, actual_target);
        end
        step();
        checks++;
        if ({IF_ID_inst, redirect_cnt, branch_cnt} !== {16'h1111, 4'd0, 4'd1}) begin
            errors++;
            $display("FAIL br_no_flush: got inst=%h rcnt=%0d bcnt=%0d expected 1111/0/1",
                     IF_ID_inst, redirect_cnt, branch_cnt);
        end
    endtask

    task automatic test_flags_busy_stall();
        do_reset();
        flags = 3'b011;
        fetch(16'h0060, 16'hC405, 2'b00, 16'h0000);
        step();
        fetch(16'h0062, 16'h2222, 2'b00, 16'h0000);
        flags_busy = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({branch_stall, wen_BTB, wen_BHT, update_PC, IF_ID_inst, IF_ID_PC_curr, branch_cnt}
                !== {4'b1000, 16'hC405, 16'h0060, 4'd0}) begin
                errors++;
                $display("FAIL gt_stall_%0d: got bst=%b w=%b%b%b inst=%h pc=%h bcnt=%0d",
                         i, branch_stall, wen_BTB, wen_BHT, update_PC, IF_ID_inst,
                         IF_ID_PC_curr, branch_cnt);
            end
            step();
        end
        flags_busy = 0;
        flags      = 3'b000;
        #1;
        checks++;
        if ({branch_stall, actual_taken, update_PC, actual_target} !== {3'b011, 16'h006C}) begin
            errors++;
            $display("FAIL gt_resolve: got %b/%h expected 011/006c",
                     {branch_stall, actual_taken, update_PC}, actual_target);
        end
        step();
        checks++;
        if ({branch_cnt, IF_ID_inst} !== {4'd1, 16'h0000}) begin
            errors++;
            $display("FAIL gt_count: got bcnt=%0d inst=%h expected 1/0000", branch_cnt, IF_ID_inst);
        end
    endtask

    task automatic test_wrap_async_reset();
        do_reset();
        fetch(16'h0004, 16'hCF00, 2'b00, 16'h0000);
        step();
        fetch(16'h0006, 16'h3333, 2'b00, 16'h0000);
        #1;
        checks++;
        if ({actual_target, update_PC} !== {16'hFE06, 1'b1}) begin
            errors++;
            $display("FAIL wrap_target: got %h upd=%b expected fe06/1", actual_target, update_PC);
        end
        #1;
        rst_n = 0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", all_out);
        end
        model_reset();
        rst_n = 1;
        step();
        checks++;
        if ({IF_ID_inst, redirect_cnt, branch_cnt} !== {16'h3333, 4'd0, 4'd0}) begin
            errors++;
            $display("FAIL reset_discard: got inst=%h rcnt=%0d bcnt=%0d expected 3333/0/0",
                     IF_ID_inst, redirect_cnt, branch_cnt);
        end
    endtask

    task automatic test_saturation_clear();
        do_reset();
        rs_data = 16'h0040;
        for (int i = 0; i < 20; i++) begin
            fetch(16'h0100 + 16'(i * 2), 16'hDE10, 2'b10, 16'h0040);
            step();
        end
        checks++;
        if (branch_cnt !== 4'hF) begin
            errors++;
            $display("FAIL bcnt_saturate: got %h expected f", branch_cnt);
        end
        for (int i = 0; i < 40; i++) begin
            fetch(16'h0200 + 16'(i * 2), 16'hDE10, 2'b00, 16'h0040);
            step();
        end
        checks++;
        if ({branch_cnt, redirect_cnt} !== 8'hFF) begin
            errors++;
            $display("FAIL rcnt_saturate: got bcnt=%h rcnt=%h expected f/f", branch_cnt, redirect_cnt);
        end
        fetch(16'h0300, 16'h4444, 2'b00, 16'h0000);
        step();
        step();
        fetch(16'h0302, 16'hDE10, 2'b00, 16'h0040);
        step();
        stats_clr = 1;
        #1;
        checks++;
        if (update_PC !== 1'b1) begin
            errors++;
            $display("FAIL clr_branch_live: got upd=%b expected 1", update_PC);
        end
        step();
        stats_clr = 0;
        checks++;
        if ({branch_cnt, redirect_cnt} !== 8'h00) begin
            errors++;
            $display("FAIL stats_clr: got bcnt=%h rcnt=%h expected 0/0", branch_cnt, redirect_cnt);
        end
    endtask

    task automatic test_random();
        exp_t        e;
        logic [15:0] pc, inst, ptgt;
        int          k;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            pc = 16'($urandom) & 16'hFFFE;
            k  = $urandom_range(0, 3);
            if (k == 0) inst = 16'($urandom);
            else        inst = {(k == 1) ? 4'hD : 4'hC, 12'($urandom)};
            case ($urandom_range(0, 2))
                0:       ptgt = 16'(b_target(int'(pc) + 2, int'(inst)));
                1:       ptgt = 16'h0040;
                default: ptgt = 16'($urandom);
            endcase
            fetch(pc, inst, 2'($urandom), ptgt);
            rs_data    = $urandom_range(0, 1) ? 16'h0040 : 16'($urandom);
            flags      = 3'($urandom);
            stall      = ($urandom_range(0, 7) == 0);
            flags_busy = ($urandom_range(0, 3) == 0);
            stats_clr  = ($urandom_range(0, 39) == 0);
            #1;
            e = model_eval();
            checks++;
            if ({actual_taken, actual_target, wen_BTB, wen_BHT, update_PC, branch_stall} !==
                {e.taken, e.target[15:0], e.wbtb, e.wbht, e.upd, e.bstall}) begin
                errors++;
                $display("FAIL rand_resolve cyc %0d: got t=%b tgt=%h btb=%b bht=%b upd=%b bst=%b expected t=%b tgt=%h btb=%b bht=%b upd=%b bst=%b",
                         cyc, actual_taken, actual_target, wen_BTB, wen_BHT, update_PC, branch_stall,
                         e.taken, e.target[15:0], e.wbtb, e.wbht, e.upd, e.bstall);
            end
            checks++;
            if ({IF_ID_PC_curr, IF_ID_prediction, IF_ID_inst} !== {m_pc[15:0], m_pred, m_inst[15:0]}) begin
                errors++;
                $display("FAIL rand_slot cyc %0d: got pc=%h pred=%b inst=%h expected pc=%h pred=%b inst=%h",
                         cyc, IF_ID_PC_curr, IF_ID_prediction, IF_ID_inst, m_pc[15:0], m_pred, m_inst[15:0]);
            end
            checks++;
            if ({branch_cnt, redirect_cnt} !== {m_bcnt[CNT_W-1:0], m_rcnt[CNT_W-1:0]}) begin
                errors++;
                $display("FAIL rand_counters cyc %0d: got %0d/%0d expected %0d/%0d",
                         cyc, branch_cnt, redirect_cnt, m_bcnt, m_rcnt);
            end
            step();
        end
        stall = 0; flags_busy = 0; stats_clr = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_taken_redirect();
        test_not_taken_mispredict();
        test_br_uncond();
        test_flags_busy_stall();
        test_wrap_async_reset();
        test_saturation_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
